// File: rtl/pcap_pkg.sv
// Constants and state type shared by the PCAP de-encapsulator and its wrapper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pcap_pkg;

  localparam int PCAP_FILE_HEADER_BYTES   = 24;
  localparam int PCAP_PACKET_HEADER_BYTES = 16;
  localparam int PCAP_INCL_LEN_OFFSET     = 8;

  // Magic 0xA1B2C3D4 as it appears on disk (little-endian), index = byte position.
  localparam logic [7:0] PCAP_MAGIC_LE [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

  typedef enum logic [2:0] {
    ST_GHDR = 3'd0,   // global file header
    ST_PHDR = 3'd1,   // per-record header
    ST_FWD  = 3'd2,   // forwarding captured bytes
    ST_DROP = 3'd3,   // consuming an oversize record
    ST_ERR  = 3'd4    // bad magic, parked until reset
  } pcap_state_t;

endpackage

// File: rtl/fifo.sv
// Generic synchronous first-word-fall-through FIFO (DEPTH must be a power of two).
// Latency: a written word is visible on dout the cycle after the write.
// Backpressure: writes ignored while full, reads ignored while empty.
//
// Ports: clock/reset (async active-low); wr_en/din/full write side;
//        rd_en/dout/empty read side, dout valid whenever empty=0.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem[rd_ptr_q];
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) count_d = count_q + (AW+1)'(1);
    else if (do_rd && !do_wr) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only observed behind count_q.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pcap_reader_top.sv
// Wraps pcap_reader between an input byte FIFO and an output frame FIFO.
// Latency: one cycle through each FIFO plus zero through the reader.
// Backpressure: in_full when the input FIFO fills; reader stalls on a full output FIFO.
//
// Ports: clock, reset (async active-low);
//        in_wr_en/in_din/in_full   : raw pcap byte stream in;
//        out_rd_en/out_dout/out_sof/out_eof/out_empty : FWFT frame stream to udp_reader;
//        frame_count/drop_count/error : reader status.
module pcap_reader_top #(
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int COUNT_WIDTH     = 16,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_wr_en,
  input  logic [7:0]             in_din,
  output logic                   in_full,
  input  logic                   out_rd_en,
  output logic [7:0]             out_dout,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   out_empty,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] drop_count,
  output logic                   error
);

  logic [7:0] rd_dout;
  logic       rd_empty, rd_en;
  logic       wr_full, wr_en;
  logic [7:0] wr_din;
  logic       wr_sof, wr_eof;
  logic [9:0] out_word;

  fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (in_wr_en),
    .din   (in_din),
    .full  (in_full),
    .rd_en (rd_en),
    .dout  (rd_dout),
    .empty (rd_empty)
  );

  pcap_reader #(
    .MAX_FRAME_BYTES (MAX_FRAME_BYTES),
    .COUNT_WIDTH     (COUNT_WIDTH)
  ) u_reader (
    .clock       (clock),
    .reset       (reset),
    .in_dout     (rd_dout),
    .in_empty    (rd_empty),
    .in_rd_en    (rd_en),
    .out_full    (wr_full),
    .out_wr_en   (wr_en),
    .out_din     (wr_din),
    .out_sof     (wr_sof),
    .out_eof     (wr_eof),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .error       (error)
  );

  // Framing bits travel alongside each byte: {sof, eof, data}.
  fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (wr_en),
    .din   ({wr_sof, wr_eof, wr_din}),
    .full  (wr_full),
    .rd_en (out_rd_en),
    .dout  (out_word),
    .empty (out_empty)
  );

  assign out_sof  = out_word[9];
  assign out_eof  = out_word[8];
  assign out_dout = out_word[7:0];

endmodule

// File: rtl/pcap_reader.sv
// Strips pcap global/record headers and forwards each captured frame with sof/eof.
// Latency: zero -- a payload byte popped from the input is pushed out the same cycle.
// Backpressure: FWD pops only when the output can accept; headers/drops pop freely.
//
// Ports: clock, reset (async active-low);
//        in_dout/in_empty/in_rd_en  : FWFT input FIFO read side;
//        out_full/out_wr_en/out_din/out_sof/out_eof : downstream FIFO write side;
//        frame_count/drop_count (saturating), error (sticky bad magic).
module pcap_reader
  import pcap_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             in_dout,
  input  logic                   in_empty,
  output logic                   in_rd_en,
  input  logic                   out_full,
  output logic                   out_wr_en,
  output logic [7:0]             out_din,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] drop_count,
  output logic                   error
);

  localparam logic [31:0] GHDR_LAST = 32'(PCAP_FILE_HEADER_BYTES - 1);
  localparam logic [31:0] PHDR_LAST = 32'(PCAP_PACKET_HEADER_BYTES - 1);
  localparam logic [31:0] LEN_LO    = 32'(PCAP_INCL_LEN_OFFSET);
  localparam logic [31:0] LEN_HI    = 32'(PCAP_INCL_LEN_OFFSET + 3);
  localparam logic [31:0] MAX_LEN   = 32'(MAX_FRAME_BYTES);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  pcap_state_t            state_q, state_d;
  logic [31:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]            rec_len_q, rec_len_d;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                   error_q, error_d;

  logic pop, push, sof_c, eof_c, last_byte;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    rec_len_d     = rec_len_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    error_d       = error_q;
    pop           = 1'b0;
    push          = 1'b0;
    sof_c         = 1'b0;
    eof_c         = 1'b0;
    last_byte     = (byte_cnt_q == rec_len_q - 32'd1);

    case (state_q)
      ST_GHDR: begin
        pop = !in_empty;
        if (pop) begin
          if ((byte_cnt_q < 32'd4) && (in_dout != PCAP_MAGIC_LE[byte_cnt_q[1:0]])) begin
            error_d    = 1'b1;
            state_d    = ST_ERR;
            byte_cnt_d = '0;
          end else if (byte_cnt_q == GHDR_LAST) begin
            state_d    = ST_PHDR;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 32'd1;
          end
        end
      end

      ST_PHDR: begin
        pop = !in_empty;
        if (pop) begin
          // incl_len sits on a 4-byte boundary, so the low two count bits
          // select which byte lane of rec_len this header byte fills.
          if ((byte_cnt_q >= LEN_LO) && (byte_cnt_q <= LEN_HI)) begin
            rec_len_d[{byte_cnt_q[1:0], 3'b000} +: 8] = in_dout;
          end
          if (byte_cnt_q == PHDR_LAST) begin
            // incl_len bytes were registered several cycles ago, so
            // rec_len_q already holds the final length here.
            byte_cnt_d = '0;
            if (rec_len_q == 32'd0)        state_d = ST_PHDR;
            else if (rec_len_q > MAX_LEN)  state_d = ST_DROP;
            else                           state_d = ST_FWD;
          end else begin
            byte_cnt_d = byte_cnt_q + 32'd1;
          end
        end
      end

      ST_FWD: begin
        push  = !in_empty && !out_full;
        pop   = push;
        sof_c = push && (byte_cnt_q == 32'd0);
        eof_c = push && last_byte;
        if (push) begin
          if (last_byte) begin
            if (frame_count_q != CNT_MAX) frame_count_d = frame_count_q + 1'b1;
            state_d    = ST_PHDR;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 32'd1;
          end
        end
      end

      ST_DROP: begin
        pop = !in_empty;
        if (pop) begin
          if (last_byte) begin
            if (drop_count_q != CNT_MAX) drop_count_d = drop_count_q + 1'b1;
            state_d    = ST_PHDR;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 32'd1;
          end
        end
      end

      ST_ERR: begin
        error_d = 1'b1;
      end

      default: begin
        state_d    = ST_GHDR;
        byte_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_GHDR;
      byte_cnt_q    <= '0;
      rec_len_q     <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      rec_len_q     <= rec_len_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      error_q       <= error_d;
    end
  end

  // Handshakes are gated by reset so nothing moves while it is held low,
  // even though the registered state already reads GHDR.
  assign in_rd_en    = reset & pop;
  assign out_wr_en   = reset & push;
  assign out_sof     = reset & sof_c;
  assign out_eof     = reset & eof_c;
  assign out_din     = in_dout;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign error       = error_q;

endmodule

// File: tb/tb_pcap_reader.sv
module tb_pcap_reader;

  localparam int MAXB = 1518;
  localparam int CW   = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    in_dout;
  logic          in_empty;
  logic          in_rd_en;
  logic          out_full;
  logic          out_wr_en;
  logic [7:0]    out_din;
  logic          out_sof;
  logic          out_eof;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] drop_count;
  logic          error;

  pcap_reader #(.MAX_FRAME_BYTES(MAXB), .COUNT_WIDTH(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_dout     (in_dout),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .out_full    (out_full),
    .out_wr_en   (out_wr_en),
    .out_din     (out_din),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .error       (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } exp_t;

  logic [7:0] src_q [$];
  exp_t       exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int push_cnt = 0;
  int first_push = -1;
  int cyc0 = 0;
  bit out_full_rand = 0;
  bit in_stall_rand = 0;
  logic last_in_rd_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    in_empty = 1'b1;
    in_dout  = 8'h00;
    out_full = 1'b0;
  endtask

  // Inputs change just after a rising edge, outputs are sampled on the falling edge.
  task automatic step();
    exp_t e;
    bit   stall;
    out_full = out_full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    stall    = in_stall_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    if (src_q.size() > 0 && !stall) begin
      in_empty = 1'b0;
      in_dout  = src_q[0];
    end else begin
      in_empty = 1'b1;
      in_dout  = 8'($urandom);
    end
    @(negedge clock);
    last_in_rd_en = in_rd_en;
    if (out_full) check("no_push_when_full", out_wr_en, 1'b0);
    if (exp_q.size() > 0 && src_q.size() == exp_q.size())
      check("fwd_rd_eq_wr", in_rd_en, out_wr_en);
    if (in_rd_en) check("rd_only_when_nonempty", in_empty, 1'b0);
    if (out_wr_en) begin
      if (first_push < 0) first_push = cyc - cyc0;
      push_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_push", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("out_din", out_din, e.d);
        check("out_sof", out_sof, e.sof);
        check("out_eof", out_eof, e.eof);
      end
    end
    if (in_rd_en && !in_empty && src_q.size() > 0) void'(src_q.pop_front());
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", (src_q.size() == 0 && exp_q.size() == 0), 1'b1);
    idle();
  endtask

  task automatic apply_reset();
    idle();
    src_q.delete();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    push_cnt   = 0;
    first_push = -1;
    cyc0       = cyc;
  endtask

  task automatic push_ghdr(input bit good);
    logic [7:0] hdr [24];
    hdr = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h02, 8'h00, 8'h04, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    if (!good) begin
      hdr[0] = 8'h4D;
      hdr[1] = 8'h3C;
    end
    for (int i = 0; i < 24; i++) src_q.push_back(hdr[i]);
  endtask

  task automatic push_record(input int len);
    logic [31:0] l;
    logic [7:0]  b;
    exp_t        e;
    l = 32'(len);
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) src_q.push_back(l[8*i +: 8]);
    for (int i = 0; i < 4; i++) src_q.push_back(l[8*i +: 8]);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      src_q.push_back(b);
      if (len <= MAXB) begin
        e.d   = b;
        e.sof = (i == 0);
        e.eof = (i == len - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int left;
    reset = 1'b0;
    idle();

    // Reset state, with data waiting at the input.
    repeat (2) @(posedge clock);
    in_empty = 1'b0;
    in_dout  = 8'hD4;
    @(negedge clock);
    check("rst_in_rd_en", in_rd_en, 1'b0);
    check("rst_out_wr_en", out_wr_en, 1'b0);
    check("rst_frame_count", frame_count, '0);
    check("rst_drop_count", drop_count, '0);
    check("rst_error", error, 1'b0);
    apply_reset();

    // 1: one 60-byte record, no stalls.
    push_ghdr(1'b1);
    push_record(60);
    drain(500, n);
    check("t1_first_push_cycle", first_push, 40);
    check("t1_total_cycles", n, 100);
    check("t1_push_count", push_cnt, 60);
    check("t1_frame_count", frame_count, 16'd1);
    check("t1_drop_count", drop_count, 16'd0);

    // 2: bad magic.
    apply_reset();
    push_ghdr(1'b0);
    push_record(10);
    left = src_q.size();
    step();
    check("t2_error_after_byte0", error, 1'b1);
    repeat (5) step();
    check("t2_bytes_consumed", left - src_q.size(), 1);
    check("t2_in_rd_en_low", last_in_rd_en, 1'b0);
    check("t2_no_push", push_cnt, 0);
    apply_reset();
    check("t2_error_cleared", error, 1'b0);

    // 3: records of 1, 0, 2000, 42 bytes with input stalls.
    apply_reset();
    in_stall_rand = 1;
    push_ghdr(1'b1);
    push_record(1);
    push_record(0);
    push_record(2000);
    push_record(42);
    drain(10000, n);
    in_stall_rand = 0;
    check("t3_push_count", push_cnt, 43);
    check("t3_frame_count", frame_count, 16'd2);
    check("t3_drop_count", drop_count, 16'd1);
    check("t3_error", error, 1'b0);

    // 4: 1024-byte record with random output backpressure.
    apply_reset();
    out_full_rand = 1;
    push_ghdr(1'b1);
    push_record(1024);
    drain(10000, n);
    out_full_rand = 0;
    check("t4_push_count", push_cnt, 1024);
    check("t4_frame_count", frame_count, 16'd1);

    // 5: reset in the middle of a 1024-byte frame, then resend.
    apply_reset();
    push_ghdr(1'b1);
    push_record(1024);
    n = 0;
    while (push_cnt < 500 && n < 2000) begin
      step();
      n++;
    end
    check("t5_reached_byte500", push_cnt, 500);
    in_empty = 1'b0;
    in_dout  = src_q[0];
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t5_rst_in_rd_en", in_rd_en, 1'b0);
    check("t5_rst_out_wr_en", out_wr_en, 1'b0);
    check("t5_rst_out_sof", out_sof, 1'b0);
    check("t5_rst_out_eof", out_eof, 1'b0);
    check("t5_rst_frame_count", frame_count, '0);
    check("t5_rst_drop_count", drop_count, '0);
    apply_reset();
    push_ghdr(1'b1);
    push_record(1024);
    drain(5000, n);
    check("t5_push_count", push_cnt, 1024);
    check("t5_frame_count", frame_count, 16'd1);
    check("t5_error", error, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
